// File: rtl/ila_seq_mux_if.sv
// rtl/ila_seq_mux_if.sv - select/config inputs and encoder-side octet outputs of ila_seq_mux
interface ila_seq_mux_if;
   logic [2:0]   i_link_mux;
   logic         i_lmfc_clk;
   logic [7:0]   i_user_data;
   logic [111:0] i_cfg_data;
   logic [7:0]   o_data;
   logic         o_is_k;
   logic         o_ila_active;
   logic [7:0]   o_mf_idx;
   logic         o_lmfc_misalign;

   modport master (
      output i_link_mux, i_lmfc_clk, i_user_data, i_cfg_data,
      input  o_data, o_is_k, o_ila_active, o_mf_idx, o_lmfc_misalign
   );

   modport slave (
      input  i_link_mux, i_lmfc_clk, i_user_data, i_cfg_data,
      output o_data, o_is_k, o_ila_active, o_mf_idx, o_lmfc_misalign
   );
endinterface

// File: rtl/ila_seq_mux.sv
// rtl/ila_seq_mux.sv - per-lane octet source: user data, continuous /K/, or ILA multiframes
module ila_seq_mux #(
   parameter int F         = 1,
   parameter int K         = 32,
   parameter int CFG_BYTES = 14
) (
   input  logic         clk,
   input  logic         rst_n,
   ila_seq_mux_if.slave bus
);
   localparam int L  = F * K;
   localparam int PW = $clog2(L);
   localparam int EW = (PW > 8) ? PW : 8;
   localparam logic [PW-1:0] P_LAST = PW'(L - 1);

   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;
   localparam logic [7:0] K28_5 = 8'hBC;

   typedef enum logic [1:0] {IDLE, WAIT_LMFC, ILA} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] p_q, p_d;
   logic [7:0]    mf_q, mf_d;
   logic [7:0]    data_q, data_d;
   logic          k_q, k_d;
   logic          act_q, act_d;
   logic          mis_q, mis_d;

   logic [7:0]    cfg_oct [CFG_BYTES];
   logic [EW-1:0] p_ext;
   logic [3:0]    cfg_idx;
   logic [7:0]    ila_data;
   logic          ila_k;

   for (genvar n = 0; n < CFG_BYTES; n++) begin : g_cfg
      assign cfg_oct[n] = bus.i_cfg_data[8*n +: 8];
   end

   // Sequencing: p_q is the position of the octet currently on o_data.
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      mf_d    = mf_q;
      mis_d   = 1'b0;
      if (bus.i_link_mux != 3'd2) begin
         state_d = IDLE;
         p_d     = '0;
         mf_d    = '0;
      end else begin
         case (state_q)
            IDLE, WAIT_LMFC: begin
               state_d = bus.i_lmfc_clk ? ILA : WAIT_LMFC;
               p_d     = '0;
               mf_d    = '0;
            end
            ILA: begin
               if (p_q == P_LAST) begin
                  p_d  = '0;
                  mf_d = (mf_q == 8'hFF) ? mf_q : mf_q + 8'd1;
               end else if (bus.i_lmfc_clk) begin
                  p_d   = '0;
                  mis_d = 1'b1;
               end else begin
                  p_d = p_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               p_d     = '0;
               mf_d    = '0;
            end
         endcase
      end
   end

   // ILA octet for the position/multiframe about to be emitted.
   always_comb begin
      p_ext    = EW'(p_d);
      cfg_idx  = p_ext[3:0] - 4'd2;
      ila_data = p_ext[7:0];
      ila_k    = 1'b0;
      if (p_d == '0) begin
         ila_data = K28_0;
         ila_k    = 1'b1;
      end else if (p_d == P_LAST) begin
         ila_data = K28_3;
         ila_k    = 1'b1;
      end else if (mf_d == 8'd1 && p_ext == EW'(1)) begin
         ila_data = K28_4;
         ila_k    = 1'b1;
      end else if (mf_d == 8'd1 && p_ext >= EW'(2) && p_ext <= EW'(15)) begin
         ila_data = cfg_oct[cfg_idx];
      end
   end

   always_comb begin
      data_d = K28_5;
      k_d    = 1'b1;
      act_d  = 1'b0;
      if (bus.i_link_mux == 3'd0) begin
         data_d = bus.i_user_data;
         k_d    = 1'b0;
      end else if (bus.i_link_mux == 3'd2 && state_d == ILA) begin
         data_d = ila_data;
         k_d    = ila_k;
         act_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p_q     <= '0;
         mf_q    <= '0;
         data_q  <= 8'h00;
         k_q     <= 1'b0;
         act_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         mf_q    <= mf_d;
         data_q  <= data_d;
         k_q     <= k_d;
         act_q   <= act_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.o_data          = data_q;
   assign bus.o_is_k          = k_q;
   assign bus.o_ila_active    = act_q;
   assign bus.o_mf_idx        = mf_q;
   assign bus.o_lmfc_misalign = mis_q;
endmodule

// File: tb/tb_ila_seq_mux.sv
// tb/tb_ila_seq_mux.sv - directed bench for ila_seq_mux with F=1 and F=2 instances
module tb_ila_seq_mux;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [2:0]   sel;
   logic         lmfc;
   logic [7:0]   user;
   logic [111:0] cfg;
   int           n_checks = 0;
   int           n_fail   = 0;

   ila_seq_mux_if bus1 ();
   ila_seq_mux_if bus2 ();

   assign bus1.i_link_mux  = sel;
   assign bus1.i_lmfc_clk  = lmfc;
   assign bus1.i_user_data = user;
   assign bus1.i_cfg_data  = cfg;
   assign bus2.i_link_mux  = sel;
   assign bus2.i_lmfc_clk  = lmfc;
   assign bus2.i_user_data = user;
   assign bus2.i_cfg_data  = cfg;

   ila_seq_mux #(.F(1), .K(32), .CFG_BYTES(14)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   ila_seq_mux #(.F(2), .K(32), .CFG_BYTES(14)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp1(input string tag, input logic [7:0] d, input logic k,
                       input logic act, input logic [7:0] mf, input logic mis);
      check({tag, ".data"}, 32'(bus1.o_data), 32'(d));
      check({tag, ".k"}, 32'(bus1.o_is_k), 32'(k));
      check({tag, ".act"}, 32'(bus1.o_ila_active), 32'(act));
      check({tag, ".mf"}, 32'(bus1.o_mf_idx), 32'(mf));
      check({tag, ".mis"}, 32'(bus1.o_lmfc_misalign), 32'(mis));
   endtask

   task automatic exp2(input string tag, input logic [7:0] d, input logic k,
                       input logic act, input logic [7:0] mf);
      check({tag, ".data2"}, 32'(bus2.o_data), 32'(d));
      check({tag, ".k2"}, 32'(bus2.o_is_k), 32'(k));
      check({tag, ".act2"}, 32'(bus2.o_ila_active), 32'(act));
      check({tag, ".mf2"}, 32'(bus2.o_mf_idx), 32'(mf));
   endtask

   initial begin
      rst_n = 1'b0;
      sel   = 3'd0;
      lmfc  = 1'b0;
      user  = 8'h00;
      for (int n = 0; n < 14; n++) cfg[8*n +: 8] = 8'hA0 + 8'(n);
      #12;
      exp1("reset", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
      exp2("reset", 8'h00, 1'b0, 1'b0, 8'd0);
      rst_n = 1'b1;
      tick();

      // 1: wait-K then multiframe 0
      sel = 3'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
         exp1("t1_wait", 8'hBC, 1'b1, 1'b0, 8'd0, 1'b0);
      end
      lmfc = 1'b1;
      tick();
      exp1("t1_r", 8'h1C, 1'b1, 1'b1, 8'd0, 1'b0);
      lmfc = 1'b0;
      for (int p = 1; p <= 30; p++) begin
         tick();
         exp1("t1_ramp", 8'(p), 1'b0, 1'b1, 8'd0, 1'b0);
      end
      tick();
      exp1("t1_a", 8'h7C, 1'b1, 1'b1, 8'd0, 1'b0);

      // 2: multiframe 1 carries config
      tick();
      exp1("t2_r", 8'h1C, 1'b1, 1'b1, 8'd1, 1'b0);
      tick();
      exp1("t2_q", 8'h9C, 1'b1, 1'b1, 8'd1, 1'b0);
      for (int p = 2; p <= 15; p++) begin
         tick();
         exp1("t2_cfg", 8'hA0 + 8'(p - 2), 1'b0, 1'b1, 8'd1, 1'b0);
      end
      for (int p = 16; p <= 30; p++) begin
         tick();
         exp1("t2_ramp", 8'(p), 1'b0, 1'b1, 8'd1, 1'b0);
      end
      tick();
      exp1("t2_a", 8'h7C, 1'b1, 1'b1, 8'd1, 1'b0);
      tick();
      exp1("t2_r2", 8'h1C, 1'b1, 1'b1, 8'd2, 1'b0);

      // 4: misaligned LMFC at p=10, then aligned LMFC at the wrap
      for (int p = 1; p <= 10; p++) begin
         tick();
         exp1("t4_ramp", 8'(p), 1'b0, 1'b1, 8'd2, 1'b0);
      end
      lmfc = 1'b1;
      tick();
      exp1("t4_mis", 8'h1C, 1'b1, 1'b1, 8'd2, 1'b1);
      lmfc = 1'b0;
      for (int p = 1; p <= 30; p++) begin
         tick();
         exp1("t4_ramp2", 8'(p), 1'b0, 1'b1, 8'd2, 1'b0);
      end
      tick();
      exp1("t4_a", 8'h7C, 1'b1, 1'b1, 8'd2, 1'b0);
      lmfc = 1'b1;
      tick();
      exp1("t4_wrap", 8'h1C, 1'b1, 1'b1, 8'd3, 1'b0);
      lmfc = 1'b0;

      // 5: leave ILA at p=7, other selects, re-entry waits for LMFC
      for (int p = 1; p <= 7; p++) begin
         tick();
         exp1("t5_ramp", 8'(p), 1'b0, 1'b1, 8'd3, 1'b0);
      end
      sel  = 3'd0;
      user = 8'h5A;
      tick();
      exp1("t5_user", 8'h5A, 1'b0, 1'b0, 8'd0, 1'b0);
      user = 8'h33;
      tick();
      exp1("t5_user2", 8'h33, 1'b0, 1'b0, 8'd0, 1'b0);
      sel = 3'd1;
      tick();
      exp1("t5_k1", 8'hBC, 1'b1, 1'b0, 8'd0, 1'b0);
      sel = 3'd7;
      tick();
      exp1("t5_k7", 8'hBC, 1'b1, 1'b0, 8'd0, 1'b0);
      sel = 3'd2;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp1("t5_wait", 8'hBC, 1'b1, 1'b0, 8'd0, 1'b0);
      end
      lmfc = 1'b1;
      tick();
      exp1("t5_r", 8'h1C, 1'b1, 1'b1, 8'd0, 1'b0);
      lmfc = 1'b0;
      tick();
      exp1("t5_p1", 8'h01, 1'b0, 1'b1, 8'd0, 1'b0);

      // 3: select 2 with coincident LMFC skips wait-K
      sel  = 3'd0;
      user = 8'h77;
      tick();
      exp1("t3_user", 8'h77, 1'b0, 1'b0, 8'd0, 1'b0);
      sel  = 3'd2;
      lmfc = 1'b1;
      tick();
      exp1("t3_r", 8'h1C, 1'b1, 1'b1, 8'd0, 1'b0);
      lmfc = 1'b0;
      tick();
      exp1("t3_p1", 8'h01, 1'b0, 1'b1, 8'd0, 1'b0);
      tick();
      exp1("t3_p2", 8'h02, 1'b0, 1'b1, 8'd0, 1'b0);

      // 6: asynchronous reset mid-ILA, then F=2 multiframe length
      #3;
      rst_n = 1'b0;
      #1;
      exp1("t6_rst", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
      exp2("t6_rst", 8'h00, 1'b0, 1'b0, 8'd0);
      tick();
      exp1("t6_hold", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
      rst_n = 1'b1;
      lmfc  = 1'b1;
      tick();
      exp2("t6_r", 8'h1C, 1'b1, 1'b1, 8'd0);
      lmfc = 1'b0;
      for (int p = 1; p <= 62; p++) begin
         tick();
         exp2("t6_ramp", 8'(p), 1'b0, 1'b1, 8'd0);
      end
      tick();
      exp2("t6_a", 8'h7C, 1'b1, 1'b1, 8'd0);
      tick();
      exp2("t6_r2", 8'h1C, 1'b1, 1'b1, 8'd1);
      tick();
      exp2("t6_q", 8'h9C, 1'b1, 1'b1, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
